// File: rtl/pe_array_controller_pkg.sv
// Shared constants and types for the pe_array controller.
//   DefaultMaxKernelSteps    : default K_MAX (accumulators per PE)
//   DefaultChannelCountWidth : default width of the per-job channel count
//   DefaultPipelineLatency   : default cycles from PE enable to accumulator update
//   pe_ctrl_state_t          : controller FSM state encoding
package pe_array_controller_pkg;

  localparam int unsigned DefaultMaxKernelSteps    = 8;
  localparam int unsigned DefaultChannelCountWidth = 10;
  localparam int unsigned DefaultPipelineLatency   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCompute,
    StDrain,
    StResult,
    StError
  } pe_ctrl_state_t;

endpackage

// File: rtl/pe_array_controller_if.sv
// Job, operand, PE-control and result signals of the pe_array controller.
//   master : controller side (drives o_* signals)
//   slave  : dispatcher / buffers / pe_array side (drives i_* signals)
interface pe_array_controller_if
  import pe_array_controller_pkg::*;
#(
  parameter int unsigned SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS = DefaultMaxKernelSteps,
  parameter int unsigned CHANNEL_COUNTER_BIT_WIDTH            = DefaultChannelCountWidth
);

  localparam int unsigned KMax = SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS;
  localparam int unsigned KSW  = (KMax > 1) ? $clog2(KMax) : 1;
  localparam int unsigned KCW  = $clog2(KMax + 1);
  localparam int unsigned CCW  = CHANNEL_COUNTER_BIT_WIDTH;

  logic           i_job_valid;
  logic           o_job_ready;
  logic [KCW-1:0] i_job_kernel_steps;
  logic [CCW-1:0] i_job_channels;
  logic           i_job_accumulate_partial;
  logic           o_job_error;
  logic           i_operand_valid;
  logic           o_pe_enable;
  logic [KSW-1:0] o_pe_accumulator_index;
  logic           o_pe_reset_accumulators;
  logic           o_pe_shift_partial_result;
  logic           o_pe_delayed_shift_partial_result_flag;
  logic           o_result_valid;
  logic           i_result_ready;
  logic           o_busy;

  modport master (
    input  i_job_valid, i_job_kernel_steps, i_job_channels, i_job_accumulate_partial,
    input  i_operand_valid, i_result_ready,
    output o_job_ready, o_job_error, o_pe_enable, o_pe_accumulator_index,
    output o_pe_reset_accumulators, o_pe_shift_partial_result,
    output o_pe_delayed_shift_partial_result_flag, o_result_valid, o_busy
  );

  modport slave (
    output i_job_valid, i_job_kernel_steps, i_job_channels, i_job_accumulate_partial,
    output i_operand_valid, i_result_ready,
    input  o_job_ready, o_job_error, o_pe_enable, o_pe_accumulator_index,
    input  o_pe_reset_accumulators, o_pe_shift_partial_result,
    input  o_pe_delayed_shift_partial_result_flag, o_result_valid, o_busy
  );

endinterface

// File: rtl/pe_array_controller_pulse_delay_line.sv
// Fixed-depth delay line for single-cycle pulses.
//   clk     : rising-edge clock
//   reset   : synchronous active-high, clears the line
//   pulse_i : pulse in
//   pulse_o : pulse_i delayed by DEPTH cycles (DEPTH >= 1)
module pulse_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_i,
  output logic pulse_o
);

  logic [DEPTH-1:0] line_q, line_d;

  always_comb begin
    line_d = (line_q << 1) | DEPTH'(pulse_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign pulse_o = line_q[DEPTH-1];

endmodule

// File: rtl/pe_array_controller.sv
// Sequences one pe_array through a convolution job: clear or preload the accumulators, stream
// K*C operand beats (outer channel loop, inner kernel-step loop) with the accumulator index,
// drain the PE pipeline, then hold the result until the consumer accepts it.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : job descriptor, operand handshake, PE controls, result handshake, status
module pe_array_controller
  import pe_array_controller_pkg::*;
#(
  parameter int unsigned SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS = DefaultMaxKernelSteps,
  parameter int unsigned CHANNEL_COUNTER_BIT_WIDTH            = DefaultChannelCountWidth,
  parameter int unsigned PE_PIPELINE_LATENCY                  = DefaultPipelineLatency
) (
  input logic                  clk,
  input logic                  reset,
  pe_array_controller_if.master bus
);

  localparam int unsigned KMax = SUPPORTED_MAX_NUMBER_OF_KERNEL_STEPS;
  localparam int unsigned KSW  = (KMax > 1) ? $clog2(KMax) : 1;
  localparam int unsigned KCW  = $clog2(KMax + 1);
  localparam int unsigned CCW  = CHANNEL_COUNTER_BIT_WIDTH;
  localparam int unsigned DCW  = (PE_PIPELINE_LATENCY > 1) ? $clog2(PE_PIPELINE_LATENCY) : 1;

  pe_ctrl_state_t state_q, state_d;
  logic [KSW-1:0] k_q, k_d;
  logic [CCW-1:0] c_q, c_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [KCW-1:0] ksteps_q, ksteps_d;
  logic [CCW-1:0] chans_q, chans_d;
  logic           accum_q, accum_d;
  logic           job_ready_q, job_ready_d;
  logic           busy_q, busy_d;
  logic           job_error_q, job_error_d;
  logic           reset_acc_q, reset_acc_d;
  logic           shift_q, shift_d;
  logic           result_valid_q, result_valid_d;

  logic pe_enable;
  logic last_k, last_c, job_illegal;

  assign pe_enable   = (state_q == StCompute) && bus.i_operand_valid;
  assign last_k      = (KCW'(k_q) == (ksteps_q - KCW'(1)));
  assign last_c      = (c_q == (chans_q - CCW'(1)));
  assign job_illegal = (bus.i_job_kernel_steps == '0) ||
                       (bus.i_job_kernel_steps > KCW'(KMax)) ||
                       (bus.i_job_channels == '0);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    drain_d     = drain_q;
    ksteps_d    = ksteps_q;
    chans_d     = chans_q;
    accum_d     = accum_q;
    job_error_d = 1'b0;
    reset_acc_d = 1'b0;
    shift_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_job_valid) begin
          ksteps_d = bus.i_job_kernel_steps;
          chans_d  = bus.i_job_channels;
          accum_d  = bus.i_job_accumulate_partial;
          if (job_illegal) begin
            state_d     = StError;
            job_error_d = 1'b1;
          end else begin
            state_d     = StInit;
            reset_acc_d = ~bus.i_job_accumulate_partial;
            shift_d     = bus.i_job_accumulate_partial;
          end
        end
      end
      StInit: begin
        k_d     = '0;
        c_d     = '0;
        state_d = StCompute;
      end
      StCompute: begin
        if (pe_enable) begin
          if (last_k) begin
            k_d = '0;
            if (last_c) begin
              state_d = StDrain;
              drain_d = '0;
            end else begin
              c_d = c_q + CCW'(1);
            end
          end else begin
            k_d = k_q + KSW'(1);
          end
        end
      end
      StDrain: begin
        if (drain_q == DCW'(PE_PIPELINE_LATENCY - 1)) begin
          state_d = StResult;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      StResult: begin
        if (bus.i_result_ready) begin
          state_d = StIdle;
        end
      end
      StError: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered from the next state so they line up with state_q.
    job_ready_d    = (state_d == StIdle);
    busy_d         = (state_d != StIdle);
    result_valid_d = (state_d == StResult);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      k_q            <= '0;
      c_q            <= '0;
      drain_q        <= '0;
      ksteps_q       <= '0;
      chans_q        <= '0;
      accum_q        <= 1'b0;
      job_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      job_error_q    <= 1'b0;
      reset_acc_q    <= 1'b0;
      shift_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      c_q            <= c_d;
      drain_q        <= drain_d;
      ksteps_q       <= ksteps_d;
      chans_q        <= chans_d;
      accum_q        <= accum_d;
      job_ready_q    <= job_ready_d;
      busy_q         <= busy_d;
      job_error_q    <= job_error_d;
      reset_acc_q    <= reset_acc_d;
      shift_q        <= shift_d;
      result_valid_q <= result_valid_d;
    end
  end

  // The delayed flag tracks when preloaded partials actually land in the accumulators.
  pulse_delay_line #(
    .DEPTH (PE_PIPELINE_LATENCY)
  ) u_shift_delay (
    .clk     (clk),
    .reset   (reset),
    .pulse_i (shift_q),
    .pulse_o (bus.o_pe_delayed_shift_partial_result_flag)
  );

  assign bus.o_job_ready               = job_ready_q;
  assign bus.o_job_error               = job_error_q;
  assign bus.o_pe_enable               = pe_enable;
  assign bus.o_pe_accumulator_index    = k_q;
  assign bus.o_pe_reset_accumulators   = reset_acc_q;
  assign bus.o_pe_shift_partial_result = shift_q;
  assign bus.o_result_valid            = result_valid_q;
  assign bus.o_busy                    = busy_q;

endmodule
